// File: rtl/lcd_probe_formatter.sv
// lcd_probe_formatter
// Builds the 32-character debug frame for the 2x16 LCD. On a trigger it
// snapshots probe 0, the selected 16-bit page of the selected probe, the
// post-increment step counter, the five pipeline-stage tags and the aux
// nibble, then emits one ASCII character per clock into a shadow buffer.
// The finished buffer is copied to strdata in a single cycle together with
// a one-cycle cls pulse, so the display never sees a half-built frame.
//
// Ports:
//   CCLK        clock
//   rst         synchronous active-high reset (aborts a conversion)
//   step        single-step pulse: counts and triggers a frame
//   refresh     pulse: triggers a frame without counting
//   probe_data  NUM_PROBES packed probe words, probe p at [p*PROBE_W +: PROBE_W]
//   probe_sel   probe shown in chars 12-15
//   page        16-bit page of the selected probe (0 = bits [15:0])
//   stage_tags  tags for f,d,e,m,w at [8s+7:8s]
//   aux         nibble shown in char 31
//   strdata     committed frame, char 0 at [255:248]
//   cls         one-cycle pulse when a frame is committed
//   busy        conversion in progress
//   step_cnt    step counter
module lcd_probe_formatter #(
    parameter int NUM_PROBES = 4,
    parameter int PROBE_W    = 32,
    parameter int CNT_W      = 8,
    localparam int SEL_W     = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1,
    localparam int PG_W      = ((PROBE_W / 16) > 1) ? $clog2(PROBE_W / 16) : 1
) (
    input  logic                          CCLK,
    input  logic                          rst,
    input  logic                          step,
    input  logic                          refresh,
    input  logic [NUM_PROBES*PROBE_W-1:0] probe_data,
    input  logic [SEL_W-1:0]              probe_sel,
    input  logic [PG_W-1:0]               page,
    input  logic [39:0]                   stage_tags,
    input  logic [3:0]                    aux,
    output logic [255:0]                  strdata,
    output logic                          cls,
    output logic                          busy,
    output logic [CNT_W-1:0]              step_cnt
);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    localparam logic [255:0] BLANK = {32{8'h20}};

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic             busy_q, busy_d;
    logic             cls_q, cls_d;
    logic [255:0]     strdata_q, strdata_d;
    logic [255:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [PG_W-1:0]  page_q;

    logic [31:0]      snap_p0_q;
    logic [15:0]      snap_pg_q;
    logic             snap_bad_q;
    logic [7:0]       snap_cnt_q;
    logic [39:0]      snap_tags_q;
    logic [3:0]       snap_aux_q;

    logic             trig_s;
    logic             cap_s;
    logic             pg_valid_s;
    logic [15:0]      pg_word_s;
    logic [7:0]       char_s;
    logic [3:0]       p0_nib_s;
    logic [3:0]       pg_nib_s;

    assign strdata  = strdata_q;
    assign cls      = cls_q;
    assign busy     = busy_q;
    assign step_cnt = cnt_q;

    // Trigger detection and counter next-state.
    always_comb begin
        trig_s = step | refresh | (probe_sel != sel_q) | (page != page_q);
        if (step) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Selected probe page; an out-of-range select or page matches no slot.
    always_comb begin
        pg_valid_s = 1'b0;
        pg_word_s  = 16'h0000;
        for (int p = 0; p < NUM_PROBES; p++) begin
            for (int g = 0; g < PROBE_W / 16; g++) begin
                if (probe_sel == SEL_W'(p) && page == PG_W'(g)) begin
                    pg_valid_s = 1'b1;
                    pg_word_s  = probe_data[p*PROBE_W + g*16 +: 16];
                end else begin
                    pg_valid_s = pg_valid_s;
                end
            end
        end
    end

    // Character generator for the current index of the snapshot.
    always_comb begin
        p0_nib_s = 4'(snap_p0_q >> {3'd7 - idx_q[2:0], 2'b00});
        pg_nib_s = 4'(snap_pg_q >> {2'd3 - idx_q[1:0], 2'b00});
        char_s   = 8'h20;
        case (idx_q[4:0])
            5'd0, 5'd1, 5'd2, 5'd3,
            5'd4, 5'd5, 5'd6, 5'd7:  char_s = hex_char(p0_nib_s);
            5'd8, 5'd11:             char_s = 8'h20;
            5'd9:                    char_s = hex_char(snap_cnt_q[7:4]);
            5'd10:                   char_s = hex_char(snap_cnt_q[3:0]);
            5'd12, 5'd13,
            5'd14, 5'd15:            char_s = snap_bad_q ? 8'h3F : hex_char(pg_nib_s);
            5'd16:                   char_s = 8'h66;
            5'd17:                   char_s = hex_char(snap_tags_q[7:4]);
            5'd18:                   char_s = hex_char(snap_tags_q[3:0]);
            5'd19:                   char_s = 8'h64;
            5'd20:                   char_s = hex_char(snap_tags_q[15:12]);
            5'd21:                   char_s = hex_char(snap_tags_q[11:8]);
            5'd22:                   char_s = 8'h65;
            5'd23:                   char_s = hex_char(snap_tags_q[23:20]);
            5'd24:                   char_s = hex_char(snap_tags_q[19:16]);
            5'd25:                   char_s = 8'h6D;
            5'd26:                   char_s = hex_char(snap_tags_q[31:28]);
            5'd27:                   char_s = hex_char(snap_tags_q[27:24]);
            5'd28:                   char_s = 8'h77;
            5'd29:                   char_s = hex_char(snap_tags_q[39:36]);
            5'd30:                   char_s = hex_char(snap_tags_q[35:32]);
            5'd31:                   char_s = hex_char(snap_aux_q);
            default:                 char_s = 8'h20;
        endcase
    end

    // Frame FSM: capture in IDLE, 32 character cycles plus one commit cycle in CONV.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        cls_d     = 1'b0;
        strdata_d = strdata_q;
        shadow_d  = shadow_q;
        cap_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_s || pending_q) begin
                    cap_s     = 1'b1;
                    state_d   = CONV;
                    idx_d     = 6'd0;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (trig_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
                if (idx_q == 6'd32) begin
                    strdata_d = shadow_q;
                    cls_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    for (int i = 0; i < 32; i++) begin
                        if (idx_q[4:0] == 5'(i)) begin
                            shadow_d[255-8*i -: 8] = char_s;
                        end else begin
                            shadow_d[255-8*i -: 8] = shadow_q[255-8*i -: 8];
                        end
                    end
                    idx_d = idx_q + 6'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                pending_d = 1'b0;
            end
        endcase
    end

    // State, output, counter and snapshot registers.
    always_ff @(posedge CCLK) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 6'd0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            cls_q       <= 1'b0;
            strdata_q   <= BLANK;
            shadow_q    <= BLANK;
            cnt_q       <= {CNT_W{1'b0}};
            sel_q       <= {SEL_W{1'b0}};
            page_q      <= {PG_W{1'b0}};
            snap_p0_q   <= 32'h0;
            snap_pg_q   <= 16'h0;
            snap_bad_q  <= 1'b0;
            snap_cnt_q  <= 8'h0;
            snap_tags_q <= 40'h0;
            snap_aux_q  <= 4'h0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            cls_q     <= cls_d;
            strdata_q <= strdata_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            sel_q     <= probe_sel;
            page_q    <= page;
            if (cap_s) begin
                snap_p0_q   <= probe_data[31:0];
                snap_pg_q   <= pg_word_s;
                snap_bad_q  <= ~pg_valid_s;
                snap_cnt_q  <= cnt_d[7:0];
                snap_tags_q <= stage_tags;
                snap_aux_q  <= aux;
            end else begin
                snap_p0_q   <= snap_p0_q;
                snap_pg_q   <= snap_pg_q;
                snap_bad_q  <= snap_bad_q;
                snap_cnt_q  <= snap_cnt_q;
                snap_tags_q <= snap_tags_q;
                snap_aux_q  <= snap_aux_q;
            end
        end
    end

endmodule

// File: tb/tb_lcd_probe_formatter.sv
// Scoreboard bench for lcd_probe_formatter: stimulus pushes the expected
// frame and its cls cycle; a monitor pops and compares on every cls.
module tb_lcd_probe_formatter;

    localparam int NP = 5;
    localparam int PW = 64;
    localparam int SW = 3;
    localparam int GW = 2;

    logic               CCLK = 1'b0;
    logic               rst = 1'b1;
    logic               step = 1'b0;
    logic               refresh = 1'b0;
    logic [NP*PW-1:0]   probe_data;
    logic [SW-1:0]      probe_sel = 3'd0;
    logic [GW-1:0]      page = 2'd0;
    logic [39:0]        stage_tags;
    logic [3:0]         aux;
    logic [255:0]       strdata;
    logic               cls;
    logic               busy;
    logic [7:0]         step_cnt;

    typedef struct {
        logic [255:0] frame;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   cls_cnt = 0;

    lcd_probe_formatter #(.NUM_PROBES(NP), .PROBE_W(PW), .CNT_W(8)) dut (
        .CCLK(CCLK), .rst(rst), .step(step), .refresh(refresh),
        .probe_data(probe_data), .probe_sel(probe_sel), .page(page),
        .stage_tags(stage_tags), .aux(aux), .strdata(strdata),
        .cls(cls), .busy(busy), .step_cnt(step_cnt)
    );

    always #5 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [127:0] tbl;
        tbl = "0123456789ABCDEF";
        hexc = tbl[(15 - n) * 8 +: 8];
    endfunction

    // Frame with the fixed probe 0 / tags / aux fields of this bench.
    function automatic logic [255:0] mk(input logic [7:0] c, input logic [31:0] mid);
        logic [71:0]  head;
        logic [127:0] tail;
        head = "3C01F00D ";
        tail = "f12d03e00mFFw9AE";
        mk = {head, hexc(c[7:4]), hexc(c[3:0]), 8'h20, mid, tail};
    endfunction

    task automatic tick();
        @(negedge CCLK);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input logic [255:0] f, input int at);
        exp_t e;
        e.frame = f;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: every cls must match the oldest expected frame and its cycle.
    always @(negedge CCLK) begin
        if (cls === 1'b1) begin
            exp_t e;
            cls_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cls frame=%h cyc=%0d", strdata, cyc);
            end else begin
                e = sb.pop_front();
                if (strdata !== e.frame || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL frame got=%h@%0d exp=%h@%0d", strdata, cyc, e.frame, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int cls_before;
        probe_data = '0;
        probe_data[63:0]    = 64'h0000_0000_3C01_F00D;
        probe_data[127:64]  = 64'h0000_0000_0000_ABCD;
        probe_data[191:128] = 64'hDEAD_BEEF_0000_1111;
        stage_tags = {8'h9A, 8'hFF, 8'h00, 8'h03, 8'h12};
        aux = 4'hE;

        // Reset and idle.
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_strdata", strdata, {32{8'h20}});
        chk("rst_cls", {255'd0, cls}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_cnt", {248'd0, step_cnt}, 256'd0);
        repeat (100) tick();
        chk("idle_no_cls", 256'(cls_cnt), 256'd0);

        // Select change triggers a frame without counting.
        c = cyc; probe_sel = 3'd1;
        push(mk(8'h00, "ABCD"), c + 34);
        wait_to(c + 40);

        // Single step.
        c = cyc; step = 1'b1;
        push(mk(8'h01, "ABCD"), c + 34);
        tick(); step = 1'b0;
        chk("step_cnt_1", {248'd0, step_cnt}, 256'd1);
        chk("busy_after_step", {255'd0, busy}, 256'd1);
        wait_to(c + 40);

        // Probe 2 pages; input change after capture must not leak in.
        c = cyc; probe_sel = 3'd2;
        push(mk(8'h01, "1111"), c + 34);
        wait_to(c + 40);
        c = cyc; page = 2'd3;
        push(mk(8'h01, "DEAD"), c + 34);
        wait_to(c + 5);
        probe_data[191:176] = 16'h5555;
        wait_to(c + 40);
        probe_data[191:176] = 16'hDEAD;
        chk("page_cnt_same", {248'd0, step_cnt}, 256'd1);
        c = cyc; probe_sel = 3'd5;
        push(mk(8'h01, "????"), c + 34);
        wait_to(c + 40);

        // Back-to-back with pending merge.
        c = cyc; step = 1'b1;
        push(mk(8'h02, "????"), c + 34);
        push(mk(8'h03, "????"), c + 68);
        tick(); step = 1'b0;
        wait_to(c + 10); refresh = 1'b1; tick(); refresh = 1'b0;
        wait_to(c + 20); step = 1'b1; tick(); step = 1'b0;
        wait_to(c + 33);
        chk("b2b_busy_k32", {255'd0, busy}, 256'd1);
        tick();
        chk("b2b_busy_k33", {255'd0, busy}, 256'd0);
        tick();
        chk("b2b_busy_k34", {255'd0, busy}, 256'd1);
        wait_to(c + 75);
        chk("b2b_cnt", {248'd0, step_cnt}, 256'd3);

        // Reset, then 256 steps to wrap the counter.
        rst = 1'b1; probe_sel = 3'd0; page = 2'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst2_cnt", {248'd0, step_cnt}, 256'd0);
        for (int i = 1; i <= 256; i++) begin
            c = cyc; step = 1'b1;
            push(mk(8'(i), "F00D"), c + 34);
            tick(); step = 1'b0;
            wait_to(c + 40);
        end
        chk("wrap_cnt", {248'd0, step_cnt}, 256'd0);
        chk("wrap_frame", strdata, mk(8'h00, "F00D"));

        // Abort: step then reset 15 cycles later.
        cls_before = cls_cnt;
        c = cyc; step = 1'b1;
        tick(); step = 1'b0;
        wait_to(c + 15); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("abort_strdata", strdata, {32{8'h20}});
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_cls", {255'd0, cls}, 256'd0);
        chk("abort_cnt", {248'd0, step_cnt}, 256'd0);
        repeat (60) tick();
        chk("abort_no_cls", 256'(cls_cnt), 256'(cls_before));
        chk("sb_empty", 256'(sb.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
